// File: rtl/mem_pkg.sv
// mem_pkg - shared types and constants for the data-memory port arbiter.
//   mem_owner_t : who owns the read-data/ack returning in the current cycle.
//   F3_*        : RISC-V load/store funct3 encodings understood by the memory.
//   owner_for_grant : maps the grant of a cycle to the owner of the next one.
package mem_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        IF    = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } mem_owner_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Owner that the response slot belongs to, given this cycle's grant.
    function automatic mem_owner_t owner_for_grant(input logic grant_if,
                                                   input logic grant_ls,
                                                   input logic ls_write);
        mem_owner_t owner;
        if (grant_if) begin
            owner = IF;
        end else if (grant_ls) begin
            owner = ls_write ? LS_WR : LS_RD;
        end else begin
            owner = NONE;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter - shares the single-port data memory between instruction
// fetch and load/store. One request is granted per cycle (LSU priority with a
// starvation guard for fetch), the request is driven straight onto the memory
// inputs, and the one-cycle-latency read data is routed back to its owner.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   if_req_valid/if_req_ready        fetch request handshake
//   if_addr                          fetch address (always a word read)
//   if_resp_valid/if_resp_data       fetch response (no backpressure)
//   ls_req_valid/ls_req_ready        load/store request handshake
//   ls_addr/ls_wdata/ls_funct3/ls_write   load/store request fields
//   ls_resp_valid/ls_resp_data       load data or store ack (data 0)
//   mem_addr/mem_value/mem_funct3/mem_read/mem_write   to memory
//   mem_data                         from memory, valid cycle after mem_read
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_funct3,
    input  logic        ls_write,
    output logic        ls_resp_valid,
    output logic [31:0] ls_resp_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_value,
    output logic [2:0]  mem_funct3,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic             grant_if_s;
    logic             grant_ls_s;
    mem_owner_t       owner_r;
    mem_owner_t       owner_nxt_s;
    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_nxt_s;

    // Grant selection: LSU wins unless fetch has waited through STARVE_LIMIT LSU grants.
    always_comb begin
        grant_if_s = 1'b0;
        grant_ls_s = 1'b0;
        if (ls_req_valid && (!if_req_valid || (starve_cnt_r < CNT_MAX))) begin
            grant_ls_s = 1'b1;
        end else if (if_req_valid) begin
            grant_if_s = 1'b1;
        end else begin
            grant_if_s = 1'b0;
            grant_ls_s = 1'b0;
        end
    end

    assign if_req_ready = grant_if_s;
    assign ls_req_ready = grant_ls_s;

    // Memory request fields taken from whichever requester is granted.
    always_comb begin
        mem_addr   = 32'd0;
        mem_value  = 32'd0;
        mem_funct3 = 3'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        if (grant_if_s) begin
            mem_addr   = if_addr;
            mem_funct3 = F3_W;
            mem_read   = 1'b1;
        end else if (grant_ls_s) begin
            mem_addr   = ls_addr;
            mem_value  = ls_wdata;
            mem_funct3 = ls_funct3;
            mem_read   = !ls_write;
            mem_write  = ls_write;
        end else begin
            mem_addr   = 32'd0;
        end
    end

    // Owner of next cycle's response slot follows this cycle's grant.
    always_comb begin
        owner_nxt_s = owner_for_grant(grant_if_s, grant_ls_s, ls_write);
    end

    // Owner state register; reset drops whatever was granted this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r <= NONE;
        end else begin
            owner_r <= owner_nxt_s;
        end
    end

    // Starvation counter: counts LSU grants that overtook a waiting fetch, saturating.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (grant_if_s || !if_req_valid) begin
            starve_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (grant_ls_s && (starve_cnt_r != CNT_MAX)) begin
            starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Response routing. Responses are suppressed while reset is high so a
    // request granted just before reset never surfaces.
    always_comb begin
        if_resp_valid = 1'b0;
        if_resp_data  = 32'd0;
        ls_resp_valid = 1'b0;
        ls_resp_data  = 32'd0;
        if (!reset) begin
            case (owner_r)
                IF: begin
                    if_resp_valid = 1'b1;
                    if_resp_data  = mem_data;
                end
                LS_RD: begin
                    ls_resp_valid = 1'b1;
                    ls_resp_data  = mem_data;
                end
                LS_WR: begin
                    ls_resp_valid = 1'b1;
                    ls_resp_data  = 32'd0;
                end
                default: begin
                    if_resp_valid = 1'b0;
                    ls_resp_valid = 1'b0;
                end
            endcase
        end else begin
            if_resp_valid = 1'b0;
            ls_resp_valid = 1'b0;
        end
    end

endmodule
